// File: rtl/demux_stream_pkg.sv
// demux_stream_pkg: constants and small helpers shared by the stream
// demultiplexer, its interface and its per-output buffer.
//   DEMUX_DEPTH    : entries per output buffer
//   CNT_W / cnt_t  : occupancy counter width / type (values 0..DEMUX_DEPTH)
//   SEL_OUT0/1     : encodings of the per-word destination select bit
package demux_stream_pkg;

  localparam int DEMUX_DEPTH = 2;
  localparam int CNT_W       = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  // A buffer is full once its occupancy reaches the buffer depth.
  function automatic logic is_full(input cnt_t count);
    return count == cnt_t'(DEMUX_DEPTH);
  endfunction

endpackage

// File: rtl/demux_stream_if.sv
// demux_stream_if: bundles the single input stream (valid/ready plus a
// destination select bit) and the two output streams of the demultiplexer.
//   master : producer/consumer side (drives in_*, outK_ready)
//   slave  : demultiplexer side (drives in_ready, outK_valid, outK_data)
interface demux_stream_if #(
  parameter int DEMUX_Width = 8
);

  logic                   in_valid;
  logic                   in_sel;
  logic [DEMUX_Width-1:0] in_data;
  logic                   in_ready;

  logic                   out0_valid;
  logic [DEMUX_Width-1:0] out0_data;
  logic                   out0_ready;

  logic                   out1_valid;
  logic [DEMUX_Width-1:0] out1_data;
  logic                   out1_ready;

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

endinterface

// File: rtl/demux_fifo2.sv
// demux_fifo2: 2-entry FIFO used as one output buffer of demux_stream.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail (ignored while full)
//   push_data  : word to write
//   full       : occupancy equals depth (from registered count only)
//   pop        : consumer takes the head word (ignored while empty)
//   valid      : buffer non-empty
//   head       : oldest stored word, read straight from the storage regs
module demux_fifo2
  import demux_stream_pkg::*;
#(
  parameter int DEMUX_Width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DEMUX_Width-1:0] push_data,
  output logic                   full,
  input  logic                   pop,
  output logic                   valid,
  output logic [DEMUX_Width-1:0] head
);

  logic [DEMUX_Width-1:0] mem [DEMUX_DEPTH];
  logic                   wr_ptr;
  logic                   rd_ptr;
  cnt_t                   count;
  logic                   do_push;
  logic                   do_pop;

  assign full    = is_full(count);
  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];

  // Guard both sides locally so a misbehaving neighbour can never
  // overwrite a live entry or advance past an empty buffer.
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_stream.sv
// demux_stream: two-way stream demultiplexer. Each accepted input word is
// steered by its select bit into one of two independent 2-entry buffers.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : demux_stream_if.slave
//              in_valid/in_sel/in_data/in_ready : producer stream
//              outK_valid/outK_data/outK_ready  : consumer stream K (K=0,1)
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int DEMUX_Width = 8
) (
  input  logic           clk,
  input  logic           rst,
  demux_stream_if.slave  bus
);

  logic full0;
  logic full1;
  logic ready;
  logic accept;
  logic push0;
  logic push1;

  // Ready depends only on the select bit and the registered occupancy of
  // the addressed buffer; a pop in the same cycle does not free a slot.
  assign ready        = (bus.in_sel == SEL_OUT1) ? !full1 : !full0;
  assign bus.in_ready = ready;

  assign accept = bus.in_valid && ready;
  assign push0  = accept && (bus.in_sel == SEL_OUT0);
  assign push1  = accept && (bus.in_sel == SEL_OUT1);

  demux_fifo2 #(.DEMUX_Width(DEMUX_Width)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (bus.in_data),
    .full      (full0),
    .pop       (bus.out0_ready),
    .valid     (bus.out0_valid),
    .head      (bus.out0_data)
  );

  demux_fifo2 #(.DEMUX_Width(DEMUX_Width)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (bus.in_data),
    .full      (full1),
    .pop       (bus.out1_ready),
    .valid     (bus.out1_valid),
    .head      (bus.out1_data)
  );

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: self-checking bench for demux_stream (DEMUX_Width=5).
// Expected behaviour comes from two queues (one per output) holding the
// words each consumer should still receive, plus hand-derived constants.
module tb_demux_stream;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_stream_if #(.DEMUX_Width(W)) bus ();

  demux_stream #(.DEMUX_Width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic         exp_rdy;
  logic         act_rdy;

  // One clock cycle: drive inputs just after the rising edge, sample
  // in_ready at the falling edge, let the edge happen, then advance the
  // queue model by the transfers the stream rules allow.
  task automatic tick(input logic v, input logic s, input logic [W-1:0] d,
                      input logic r0, input logic r1);
    logic pop0, pop1;
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    @(negedge clk);
    exp_rdy = ((s ? q1.size() : q0.size()) < 2);
    act_rdy = bus.in_ready;
    pop0 = r0 && (q0.size() > 0);
    pop1 = r1 && (q1.size() > 0);
    @(posedge clk);
    #1;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (v && exp_rdy) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_sel = 0; bus.in_data = '0;
    bus.out0_ready = 0; bus.out1_ready = 0;
    #2;
    n_checks++; if ({bus.out0_valid, bus.out1_valid} !== 2'b00) $display("FAIL rst_valids: got %b want 00", {bus.out0_valid, bus.out1_valid}); else n_pass++;
    n_checks++; if ({bus.out0_data, bus.out1_data} !== 10'h0) $display("FAIL rst_data: got %h want 000", {bus.out0_data, bus.out1_data}); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.in_ready); else n_pass++;
    @(posedge clk); #1 rst = 0;
    // Load out0 with two words, then reset between edges.
    tick(1, 0, 5'h15, 0, 0);
    tick(1, 0, 5'h0A, 0, 0);
    n_checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 5'h15) $display("FAIL midrst_loaded: got v=%b d=%h want v=1 d=15", bus.out0_valid, bus.out0_data); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_full: got %b want 0", bus.in_ready); else n_pass++;
    @(negedge clk);
    bus.in_valid = 0;
    rst = 1;
    #1;
    n_checks++; if ({bus.out0_valid, bus.out1_valid} !== 2'b00) $display("FAIL midrst_valids: got %b want 00", {bus.out0_valid, bus.out1_valid}); else n_pass++;
    n_checks++; if (bus.out0_data !== 5'h00) $display("FAIL midrst_data: got %h want 00", bus.out0_data); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", bus.in_ready); else n_pass++;
    #1 rst = 0;
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    n_checks++; if (bus.out0_valid !== 1'b0) $display("FAIL postrst_empty: got %b want 0", bus.out0_valid); else n_pass++;
    tick(1, 0, 5'h03, 0, 0);
    n_checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 5'h03 || bus.out1_valid !== 1'b0) $display("FAIL postrst_push: got v0=%b d0=%h v1=%b want 1 03 0", bus.out0_valid, bus.out0_data, bus.out1_valid); else n_pass++;
    tick(0, 0, 5'h00, 1, 0);
    n_checks++; if (bus.out0_valid !== 1'b0) $display("FAIL postrst_alone: got %b want 0", bus.out0_valid); else n_pass++;
  endtask

  task automatic test_steering();
    tick(1, 0, 5'h15, 1, 1);
    n_checks++; if (act_rdy !== 1'b1) $display("FAIL steer_rdy1: got %b want 1", act_rdy); else n_pass++;
    n_checks++; if ({bus.out0_valid, bus.out0_data, bus.out1_valid} !== {1'b1, 5'h15, 1'b0}) $display("FAIL steer_w1: got v0=%b d0=%h v1=%b want 1 15 0", bus.out0_valid, bus.out0_data, bus.out1_valid); else n_pass++;
    tick(1, 1, 5'h0A, 1, 1);
    n_checks++; if ({bus.out0_valid, bus.out1_valid, bus.out1_data} !== {1'b0, 1'b1, 5'h0A}) $display("FAIL steer_w2: got v0=%b v1=%b d1=%h want 0 1 0a", bus.out0_valid, bus.out1_valid, bus.out1_data); else n_pass++;
    tick(1, 0, 5'h1F, 1, 1);
    n_checks++; if ({bus.out0_valid, bus.out0_data, bus.out1_valid} !== {1'b1, 5'h1F, 1'b0}) $display("FAIL steer_w3: got v0=%b d0=%h v1=%b want 1 1f 0", bus.out0_valid, bus.out0_data, bus.out1_valid); else n_pass++;
    tick(0, 0, 5'h00, 1, 1);
    n_checks++; if ({bus.out0_valid, bus.out1_valid} !== 2'b00) $display("FAIL steer_drain: got %b want 00", {bus.out0_valid, bus.out1_valid}); else n_pass++;
  endtask

  task automatic test_backpressure();
    tick(1, 0, 5'h01, 0, 0);
    tick(1, 0, 5'h02, 0, 0);
    n_checks++; if (act_rdy !== 1'b1) $display("FAIL bp_second_rdy: got %b want 1", act_rdy); else n_pass++;
    tick(1, 0, 5'h03, 0, 0);
    n_checks++; if (act_rdy !== 1'b0) $display("FAIL bp_third_rdy: got %b want 0", act_rdy); else n_pass++;
    n_checks++; if (bus.out0_data !== 5'h01) $display("FAIL bp_head01: got %h want 01", bus.out0_data); else n_pass++;
    // Pop while full: still not ready (no bypass).
    tick(1, 0, 5'h03, 1, 0);
    n_checks++; if (act_rdy !== 1'b0) $display("FAIL bp_nobypass: got %b want 0", act_rdy); else n_pass++;
    n_checks++; if (bus.out0_data !== 5'h02) $display("FAIL bp_head02: got %h want 02", bus.out0_data); else n_pass++;
    tick(1, 0, 5'h03, 1, 0);
    n_checks++; if (act_rdy !== 1'b1) $display("FAIL bp_accept03: got %b want 1", act_rdy); else n_pass++;
    n_checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 5'h03) $display("FAIL bp_head03: got v=%b d=%h want 1 03", bus.out0_valid, bus.out0_data); else n_pass++;
    tick(0, 0, 5'h00, 1, 0);
    n_checks++; if (bus.out0_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", bus.out0_valid); else n_pass++;
  endtask

  task automatic test_independence();
    tick(1, 0, 5'h0C, 0, 0);
    tick(1, 0, 5'h0D, 0, 0);
    tick(1, 1, 5'h11, 0, 0);
    n_checks++; if (act_rdy !== 1'b1) $display("FAIL indep_rdy: got %b want 1", act_rdy); else n_pass++;
    n_checks++; if ({bus.out1_valid, bus.out1_data, bus.out0_valid, bus.out0_data} !== {1'b1, 5'h11, 1'b1, 5'h0C}) $display("FAIL indep_out: got v1=%b d1=%h v0=%b d0=%h want 1 11 1 0c", bus.out1_valid, bus.out1_data, bus.out0_valid, bus.out0_data); else n_pass++;
    tick(0, 0, 5'h00, 1, 1);
    n_checks++; if ({bus.out0_valid, bus.out0_data, bus.out1_valid} !== {1'b1, 5'h0D, 1'b0}) $display("FAIL indep_bothpop: got v0=%b d0=%h v1=%b want 1 0d 0", bus.out0_valid, bus.out0_data, bus.out1_valid); else n_pass++;
    tick(0, 0, 5'h00, 1, 1);
  endtask

  task automatic test_push_pop();
    logic [W-1:0] seq [3];
    seq[0] = 5'h05; seq[1] = 5'h06; seq[2] = 5'h07;
    tick(1, 1, 5'h04, 0, 0);
    n_checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 5'h04) $display("FAIL pp_head04: got v=%b d=%h want 1 04", bus.out1_valid, bus.out1_data); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, seq[i], 0, 1);
      n_checks++; if (act_rdy !== 1'b1) $display("FAIL pp_rdy%0d: got %b want 1", i, act_rdy); else n_pass++;
      n_checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== seq[i]) $display("FAIL pp_head%0d: got v=%b d=%h want 1 %h", i, bus.out1_valid, bus.out1_data, seq[i]); else n_pass++;
      n_checks++; if (int'(dut.u_fifo1.count) !== 1) $display("FAIL pp_count%0d: got %0d want 1", i, dut.u_fifo1.count); else n_pass++;
    end
    tick(0, 1, 5'h00, 0, 1);
    n_checks++; if (bus.out1_valid !== 1'b0) $display("FAIL pp_drain: got %b want 0", bus.out1_valid); else n_pass++;
  endtask

  task automatic test_idle();
    tick(1, 0, 5'h1A, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 1'($urandom_range(1)), 5'($urandom), 0, 0);
      n_checks++; if ({bus.out0_valid, bus.out0_data, bus.out1_valid} !== {1'b1, 5'h1A, 1'b0}) $display("FAIL idle_%0d: got v0=%b d0=%h v1=%b want 1 1a 0", i, bus.out0_valid, bus.out0_data, bus.out1_valid); else n_pass++;
      n_checks++; if ({dut.u_fifo0.count, dut.u_fifo1.count} !== 4'b0100) $display("FAIL idle_cnt%0d: got %b want 0100", i, {dut.u_fifo0.count, dut.u_fifo1.count}); else n_pass++;
    end
    tick(0, 0, 5'h00, 1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 5'($urandom),
           1'($urandom_range(2) != 0), 1'($urandom_range(2) != 0));
      n_checks++; if (act_rdy !== exp_rdy) $display("FAIL rnd_rdy%0d: got %b want %b", i, act_rdy, exp_rdy); else n_pass++;
      n_checks++; if (bus.out0_valid !== (q0.size() != 0)) $display("FAIL rnd_v0_%0d: got %b want %b", i, bus.out0_valid, q0.size() != 0); else n_pass++;
      n_checks++; if (bus.out1_valid !== (q1.size() != 0)) $display("FAIL rnd_v1_%0d: got %b want %b", i, bus.out1_valid, q1.size() != 0); else n_pass++;
      if (q0.size() != 0) begin
        n_checks++; if (bus.out0_data !== q0[0]) $display("FAIL rnd_d0_%0d: got %h want %h", i, bus.out0_data, q0[0]); else n_pass++;
      end
      if (q1.size() != 0) begin
        n_checks++; if (bus.out1_data !== q1[0]) $display("FAIL rnd_d1_%0d: got %h want %h", i, bus.out1_data, q1[0]); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_steering();
    test_backpressure();
    test_independence();
    test_push_pop();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
